// File: rtl/x_serial_out.sv
// -----------------------------------------------------------------------------
// x_serial_out
//
// Parallel-to-serial shifter. A word on din is captured when load is sampled
// high while the block is idle. It is then shifted out one bit per clock on
// sout, either LSB first or MSB first. The hold input stalls the shift. A
// single-cycle done pulse follows the last bit, and the block then returns to
// idle.
//
// Parameters
//   WIDTH      data word width in bits (2..32)
//   MSB_FIRST  0 = shift LSB first, 1 = shift MSB first
//
// Ports
//   clk         in   single clock, rising-edge active
//   rst         in   asynchronous, active-high reset
//   load        in   capture din and start a transfer (accepted only when ready)
//   din         in   parallel word, WIDTH bits
//   hold        in   stall request; freezes the shift while high
//   ready       out  high when a load will be accepted
//   busy        out  high while a transfer (including its done cycle) is active
//   sout        out  current serial data bit
//   sout_valid  out  high when sout carries a valid bit this cycle
//   done        out  one-cycle pulse after the last bit
//
// Every output is decoded from registered state only. No input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module x_serial_out #(
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             hold,
    output logic             ready,
    output logic             busy,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    // Counter wide enough to hold WIDTH-1. It never goes past that value.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state,  state_nx;
    logic [WIDTH-1:0] shreg,  shreg_nx;
    logic [CW-1:0]    cnt,    cnt_nx;
    // hold as sampled at the previous edge; gates sout_valid during SHIFT.
    logic             hold_q, hold_nx;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: all state updates use non-blocking assignments so every register
    // samples values from before the edge, whatever order the statements run in.
    // The shift register is an ordinary flop bank, not a memory. Clearing it on
    // reset therefore costs nothing, and sout is guaranteed to be 0 until the
    // first load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            hold_q <= 1'b0;
        end else begin
            state  <= state_nx;
            shreg  <= shreg_nx;
            cnt    <= cnt_nx;
            hold_q <= hold_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first. A path that
    // misses an assignment then cannot infer a latch.
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        // hold is tracked only while shifting. In IDLE and DONE it has no
        // effect, and the first bit after a load is always presented as valid.
        hold_nx  = 1'b0;

        unique case (state)
            IDLE: begin
                // din is captured here and nowhere else. Later changes on din
                // therefore cannot alter the word being shifted out.
                if (load) begin
                    shreg_nx = din;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end
            end

            SHIFT: begin
                hold_nx = hold;
                if (!hold) begin
                    // Move the next bit toward the output end and zero-fill
                    // behind it.
                    if (MSB_FIRST != 0) begin
                        shreg_nx = {shreg[WIDTH-2:0], 1'b0};
                    end else begin
                        shreg_nx = {1'b0, shreg[WIDTH-1:1]};
                    end

                    if (cnt == CNT_LAST) begin
                        // The last bit has been consumed. The counter stays at
                        // WIDTH-1 so it never leaves its legal range.
                        state_nx = DONE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end

            DONE: begin
                // Leave after exactly one cycle. A load seen here is dropped,
                // because ready is low in this state.
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (registered state only)
    // -------------------------------------------------------------------------
    always_comb begin
        ready      = 1'b0;
        busy       = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;

        unique case (state)
            IDLE: begin
                ready = 1'b1;
            end

            SHIFT: begin
                busy = 1'b1;
                // A stalled cycle shows the same bit again, marked invalid, so
                // the bit is counted once by the receiver.
                sout_valid = ~hold_q;
                sout = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
            end

            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end

            default: begin
                ready = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_x_serial_out.sv
// -----------------------------------------------------------------------------
// tb_x_serial_out
//
// Drives two x_serial_out instances (LSB-first and MSB-first, WIDTH=16) with
// shared stimulus. For each accepted load, a reference model pushes the
// expected serial bit stream for each instance into a queue. It also pushes
// the clock cycle at which done must appear. That cycle is derived from the
// load cycle plus WIDTH plus the number of stalled cycles. Independent
// monitors pop and compare whenever a DUT presents a valid bit or a done
// pulse.
// -----------------------------------------------------------------------------
module tb_x_serial_out;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic         hold;
    logic [W-1:0] din;

    logic ready0, busy0, sout0, sv0, done0;
    logic ready1, busy1, sout1, sv1, done1;

    x_serial_out #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .load(load), .din(din), .hold(hold),
        .ready(ready0), .busy(busy0), .sout(sout0), .sout_valid(sv0), .done(done0)
    );

    x_serial_out #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .load(load), .din(din), .hold(hold),
        .ready(ready1), .busy(busy1), .sout(sout1), .sout_valid(sv1), .done(done1)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far. It is read only on falling edges.
    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    bit exp_q0[$];
    bit exp_q1[$];
    int done_q0[$];
    int done_q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the bit order is taken directly from the word.
    task automatic push_bits(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            exp_q0.push_back(w[i]);
            exp_q1.push_back(w[W-1-i]);
        end
    endtask

    // ---------------------------------------------------------------- monitors
    always @(negedge clk) begin
        if (!rst) begin
            if (sv0) begin
                if (exp_q0.size() == 0) check("lsb_unexpected_bit", sv0, 0);
                else                    check("lsb_sout", sout0, exp_q0.pop_front());
            end
            if (done0) begin
                if (done_q0.size() == 0) check("lsb_unexpected_done", done0, 0);
                else                     check("lsb_done_cycle", cyc, done_q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (sv1) begin
                if (exp_q1.size() == 0) check("msb_unexpected_bit", sv1, 0);
                else                    check("msb_sout", sout1, exp_q1.pop_front());
            end
            if (done1) begin
                if (done_q1.size() == 0) check("msb_unexpected_done", done1, 0);
                else                     check("msb_done_cycle", cyc, done_q1.pop_front());
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    // Random stall pattern. Bit k is the hold value for edge N+1+k. The
    // pattern ends once W non-stalled edges have been produced.
    function automatic logic [63:0] rand_holds();
        logic [63:0] p     = '0;
        int          zeros = 0;
        int          ones  = 0;
        int          k     = 0;
        while (zeros < W) begin
            if (ones < 12 && $urandom_range(3) == 0) begin
                p[k] = 1'b1;
                ones++;
            end else begin
                zeros++;
            end
            k++;
        end
        return p;
    endfunction

    // Runs one full transfer. It must be called on a falling edge; the load is
    // sampled on the next rising edge. stray=1 adds random load pulses during
    // the shift. A load pulse is always driven in the DONE cycle, and din is
    // randomized after capture. The task returns on the falling edge after the
    // IDLE re-entry, so a back-to-back call is spaced W+2 cycles plus stalls.
    task automatic do_xfer(input logic [W-1:0] w, input logic [63:0] hp, input bit stray);
        int nh    = 0;
        int edges = 0;
        int zeros = 0;
        while (zeros < W) begin
            if (hp[edges]) nh++;
            else           zeros++;
            edges++;
        end

        load = 1'b1;
        din  = w;
        hold = 1'($urandom_range(1));   // hold while idle must not matter
        push_bits(w);
        done_q0.push_back(cyc + 1 + W + nh);
        done_q1.push_back(cyc + 1 + W + nh);
        @(negedge clk);

        for (int k = 0; k < edges; k++) begin
            hold = hp[k];
            load = stray ? 1'($urandom_range(1)) : 1'b0;
            din  = W'($urandom);
            @(negedge clk);
        end

        // This is the DONE cycle. Load must be dropped here.
        check("done_cycle_ready", ready0, 0);
        check("done_cycle_busy", busy1, 1);
        load = 1'b1;
        din  = W'($urandom);
        hold = 1'($urandom_range(1));
        @(negedge clk);

        check("idle_ready", ready1, 1);
        check("idle_busy", busy0, 0);
        load = 1'b0;
        hold = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        hold = 1'b0;
        din  = '0;
        #1;
        check("reset_ready", ready0, 1);
        check("reset_busy", busy0, 0);
        check("reset_sout_valid", sv0, 0);
        check("reset_done", done1, 0);
        check("reset_sout", sout1, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Load on the first edge after reset release. A5C3 LSB-first gives
        // 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
        do_xfer(16'hA5C3, 64'h0, 1'b0);
        // 8001 MSB-first gives 1, fourteen 0s, then 1.
        do_xfer(16'h8001, 64'h0, 1'b0);
        // FFFF stalled for 3 cycles after bit 4; done moves to N+19.
        do_xfer(16'hFFFF, 64'h70, 1'b0);
        // Stray loads mid-shift and in DONE, with din scrambled after capture.
        do_xfer(16'h5A3C, 64'h0, 1'b1);

        // Reset after bit 7 of a transfer: immediate idle outputs, no done.
        load = 1'b1;
        din  = 16'h00FF;
        push_bits(16'h00FF);
        @(negedge clk);
        load = 1'b0;
        din  = W'($urandom);
        repeat (7) @(negedge clk);   // bit 7 is now on sout
        #2 rst = 1'b1;
        #1;
        check("abort_ready", ready0, 1);
        check("abort_busy", busy0, 0);
        check("abort_sout_valid", sv0, 0);
        check("abort_done", done0, 0);
        check("abort_msb_ready", ready1, 1);
        check("abort_msb_sout_valid", sv1, 0);
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_xfer(16'h0001, 64'h0, 1'b0);

        // Randomized back-to-back transfers with random stalls and stray loads.
        for (int t = 0; t < 24; t++) begin
            do_xfer(W'($urandom), rand_holds(), 1'($urandom_range(1)));
        end

        repeat (3) @(negedge clk);
        check("lsb_bits_left", exp_q0.size(), 0);
        check("msb_bits_left", exp_q1.size(), 0);
        check("lsb_done_left", done_q0.size(), 0);
        check("msb_done_left", done_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
